// File: rtl/rob_commit.sv
// rob_commit: 16-entry reorder buffer. Allocates entries at dispatch, collects
// ALU/LSB writebacks, commits in program order and flushes on mispredict.
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global stall when low)
//   dc_*        : dispatch from decoder; rob_full / rob_tail_id back to it
//   qry_*       : combinational operand lookup from registered state
//   rs_*, lsb_* : writebacks from the ALU and the load/store buffer
//   commit_*    : register-file write pulse; store_commit releases stores
//   bp_*        : branch outcome at commit; rob_clear/clear_pc flush + restart
//   halt        : sticky once an EXIT entry commits
module rob_commit #(
    parameter int unsigned ROB_SIZE = 16,
    parameter int unsigned ROB_W    = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             dc_valid,
    input  logic [1:0]       dc_kind,
    input  logic [4:0]       dc_rd,
    input  logic [31:0]      dc_pc,
    input  logic             dc_pred_taken,
    input  logic [31:0]      dc_alt_pc,
    output logic             rob_full,
    output logic [ROB_W-1:0] rob_tail_id,
    input  logic [ROB_W-1:0] qry_i_id,
    input  logic [ROB_W-1:0] qry_j_id,
    output logic             qry_i_ready,
    output logic             qry_j_ready,
    output logic [31:0]      qry_i_value,
    output logic [31:0]      qry_j_value,
    input  logic             rs_has_output,
    input  logic [ROB_W-1:0] rs_rob_id,
    input  logic [31:0]      rs_output,
    input  logic             is_lsb,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_res,
    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [ROB_W-1:0] commit_rob_id,
    output logic             store_commit,
    output logic             bp_valid,
    output logic [31:0]      bp_pc,
    output logic             bp_taken,
    output logic             rob_clear,
    output logic [31:0]      clear_pc,
    output logic             halt
);

    localparam int unsigned CNT_W = ROB_W + 1;

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_EXIT   = 2'd3
    } kind_t;

    typedef struct packed {
        kind_t       kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] alt_pc;
        logic [31:0] value;
    } entry_t;

    entry_t              ent [ROB_SIZE];
    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_W-1:0]    head;
    logic [ROB_W-1:0]    tail;
    logic [CNT_W-1:0]    count;

    entry_t           head_ent;
    logic             active;
    logic             do_disp;
    logic             do_commit;
    logic             mispredict;
    logic             dc_ready;
    logic [CNT_W-1:0] count_next;

    assign rob_tail_id = tail;

    // Operand lookup sees only registered state; the RS handles its own bypass.
    assign qry_i_ready = busy[qry_i_id] & ready[qry_i_id];
    assign qry_j_ready = busy[qry_j_id] & ready[qry_j_id];
    assign qry_i_value = ent[qry_i_id].value;
    assign qry_j_value = ent[qry_j_id].value;

    // Control decode: the flush cycle and a global stall both freeze inputs.
    always_comb begin
        head_ent   = ent[head];
        active     = rdy_in & ~rob_clear;
        do_disp    = active & dc_valid & ~rob_full & ~halt;
        do_commit  = active & busy[head] & ready[head] & ~halt;
        mispredict = do_commit & (head_ent.kind == KIND_BRANCH) &
                     (head_ent.value[0] != head_ent.pred_taken);
        dc_ready   = (dc_kind == 2'(KIND_STORE)) | (dc_kind == 2'(KIND_EXIT));
        count_next = count + CNT_W'(do_disp) - CNT_W'(do_commit);
    end

    // Buffer state, commit pulses and held commit/branch outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ent           <= '{default: '0};
            busy          <= '0;
            ready         <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            rob_full      <= 1'b0;
            commit_valid  <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_rob_id <= '0;
            store_commit  <= 1'b0;
            bp_valid      <= 1'b0;
            bp_pc         <= '0;
            bp_taken      <= 1'b0;
            rob_clear     <= 1'b0;
            clear_pc      <= '0;
            halt          <= 1'b0;
        end else begin
            commit_valid <= 1'b0;
            store_commit <= 1'b0;
            bp_valid     <= 1'b0;
            rob_clear    <= 1'b0;

            if (active) begin
                if (rs_has_output && busy[rs_rob_id]) begin
                    ent[rs_rob_id].value <= rs_output;
                    ready[rs_rob_id]     <= 1'b1;
                end
                if (is_lsb && busy[lsb_rob_id]) begin
                    ent[lsb_rob_id].value <= lsb_res;
                    ready[lsb_rob_id]     <= 1'b1;
                end

                if (do_disp) begin
                    ent[tail] <= '{kind:       kind_t'(dc_kind),
                                   rd:         dc_rd,
                                   pc:         dc_pc,
                                   pred_taken: dc_pred_taken,
                                   alt_pc:     dc_alt_pc,
                                   value:      32'd0};
                    busy[tail]  <= 1'b1;
                    ready[tail] <= dc_ready;
                end

                if (do_commit) begin
                    busy[head]    <= 1'b0;
                    ready[head]   <= 1'b0;
                    commit_rob_id <= head;
                    case (head_ent.kind)
                        KIND_REG: begin
                            commit_valid <= 1'b1;
                            commit_rd    <= head_ent.rd;
                            commit_value <= head_ent.value;
                        end
                        KIND_STORE:  store_commit <= 1'b1;
                        KIND_BRANCH: begin
                            bp_valid <= 1'b1;
                            bp_pc    <= head_ent.pc;
                            bp_taken <= head_ent.value[0];
                        end
                        KIND_EXIT:   halt <= 1'b1;
                        default:     ;
                    endcase
                end

                // Mispredict empties the buffer, overriding this edge's dispatch/writebacks.
                if (mispredict) begin
                    busy      <= '0;
                    ready     <= '0;
                    head      <= '0;
                    tail      <= '0;
                    count     <= '0;
                    rob_full  <= 1'b0;
                    rob_clear <= 1'b1;
                    clear_pc  <= head_ent.alt_pc;
                end else begin
                    if (do_disp) begin
                        tail <= tail + ROB_W'(1);
                    end
                    if (do_commit) begin
                        head <= head + ROB_W'(1);
                    end
                    count    <= count_next;
                    rob_full <= (count_next == CNT_W'(ROB_SIZE));
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed self-checking bench for rob_commit.
module tb_rob_commit;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        dc_valid;
    logic [1:0]  dc_kind;
    logic [4:0]  dc_rd;
    logic [31:0] dc_pc;
    logic        dc_pred_taken;
    logic [31:0] dc_alt_pc;
    logic        rob_full;
    logic [3:0]  rob_tail_id;
    logic [3:0]  qry_i_id;
    logic [3:0]  qry_j_id;
    logic        qry_i_ready;
    logic        qry_j_ready;
    logic [31:0] qry_i_value;
    logic [31:0] qry_j_value;
    logic        rs_has_output;
    logic [3:0]  rs_rob_id;
    logic [31:0] rs_output;
    logic        is_lsb;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_res;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [3:0]  commit_rob_id;
    logic        store_commit;
    logic        bp_valid;
    logic [31:0] bp_pc;
    logic        bp_taken;
    logic        rob_clear;
    logic [31:0] clear_pc;
    logic        halt;

    int tests_run;
    int tests_failed;

    rob_commit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dc_valid(dc_valid), .dc_kind(dc_kind), .dc_rd(dc_rd), .dc_pc(dc_pc),
        .dc_pred_taken(dc_pred_taken), .dc_alt_pc(dc_alt_pc),
        .rob_full(rob_full), .rob_tail_id(rob_tail_id),
        .qry_i_id(qry_i_id), .qry_j_id(qry_j_id),
        .qry_i_ready(qry_i_ready), .qry_j_ready(qry_j_ready),
        .qry_i_value(qry_i_value), .qry_j_value(qry_j_value),
        .rs_has_output(rs_has_output), .rs_rob_id(rs_rob_id), .rs_output(rs_output),
        .is_lsb(is_lsb), .lsb_rob_id(lsb_rob_id), .lsb_res(lsb_res),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_rob_id(commit_rob_id), .store_commit(store_commit),
        .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken),
        .rob_clear(rob_clear), .clear_pc(clear_pc), .halt(halt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic idle_inputs();
        dc_valid = 0; dc_kind = 0; dc_rd = 0; dc_pc = 0; dc_pred_taken = 0; dc_alt_pc = 0;
        qry_i_id = 0; qry_j_id = 0;
        rs_has_output = 0; rs_rob_id = 0; rs_output = 0;
        is_lsb = 0; lsb_rob_id = 0; lsb_res = 0;
    endtask

    // Advance one edge, land 1ns after it, and drop per-cycle stimulus.
    task automatic step();
        @(posedge clk_in);
        #1;
        idle_inputs();
    endtask

    task automatic disp(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc,
                        input logic pred, input logic [31:0] alt);
        dc_valid = 1; dc_kind = kind; dc_rd = rd; dc_pc = pc; dc_pred_taken = pred; dc_alt_pc = alt;
    endtask

    task automatic do_reset();
        rdy_in = 1;
        rst_in = 0;
        idle_inputs();
        step();
        step();
        rst_in = 1;
    endtask

    task automatic test_reset();
        rdy_in = 1;
        rst_in = 0;
        idle_inputs();
        #2;
        tests_run++; if ({commit_valid, store_commit, bp_valid, rob_clear, halt, rob_full} !== 6'b0) begin tests_failed++; $display("FAIL reset_flags got %b exp 000000", {commit_valid, store_commit, bp_valid, rob_clear, halt, rob_full}); end
        tests_run++; if (rob_tail_id !== 4'd0) begin tests_failed++; $display("FAIL reset_tail got %0d exp 0", rob_tail_id); end
        tests_run++; if ({commit_rd, commit_value, bp_pc, clear_pc, commit_rob_id} !== 105'd0) begin tests_failed++; $display("FAIL reset_held got %h exp 0", {commit_rd, commit_value, bp_pc, clear_pc, commit_rob_id}); end
        step();
        rst_in = 1;
        step();
        tests_run++; if ({commit_valid, rob_full, qry_i_ready} !== 3'b0) begin tests_failed++; $display("FAIL reset_idle got %b exp 000", {commit_valid, rob_full, qry_i_ready}); end
    endtask

    task automatic test_basic();
        do_reset();
        disp(2'd0, 5'd5, 32'h100, 0, 0);
        step();
        tests_run++; if (rob_tail_id !== 4'd1) begin tests_failed++; $display("FAIL basic_tail got %0d exp 1", rob_tail_id); end
        rs_has_output = 1; rs_rob_id = 0; rs_output = 32'h1234;
        step();
        qry_i_id = 0; qry_j_id = 0;
        #1;
        tests_run++; if ({qry_i_ready, qry_i_value} !== {1'b1, 32'h1234}) begin tests_failed++; $display("FAIL basic_qry_i got %b/%h exp 1/00001234", qry_i_ready, qry_i_value); end
        tests_run++; if ({qry_j_ready, qry_j_value} !== {1'b1, 32'h1234}) begin tests_failed++; $display("FAIL basic_qry_j got %b/%h exp 1/00001234", qry_j_ready, qry_j_value); end
        tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_commit got %b exp 0", commit_valid); end
        step();
        tests_run++; if ({commit_valid, commit_rd, commit_value, commit_rob_id} !== {1'b1, 5'd5, 32'h1234, 4'd0}) begin tests_failed++; $display("FAIL basic_commit got %b rd=%0d v=%h id=%0d exp 1 rd=5 v=00001234 id=0", commit_valid, commit_rd, commit_value, commit_rob_id); end
        step();
        tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_pulse got %b exp 0", commit_valid); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            disp(2'd0, 5'(i + 1), 32'(32'h200 + 4 * i), 0, 0);
            step();
        end
        tests_run++; if ({rob_full, rob_tail_id} !== {1'b1, 4'd0}) begin tests_failed++; $display("FAIL full_set got %b/%0d exp 1/0", rob_full, rob_tail_id); end
        disp(2'd0, 5'd31, 32'h300, 0, 0);
        rs_has_output = 1; rs_rob_id = 0; rs_output = 32'hAA;
        step();
        tests_run++; if ({rob_full, rob_tail_id} !== {1'b1, 4'd0}) begin tests_failed++; $display("FAIL full_refuse got %b/%0d exp 1/0", rob_full, rob_tail_id); end
        step();
        tests_run++; if ({commit_valid, commit_rd, commit_value, rob_full} !== {1'b1, 5'd1, 32'hAA, 1'b0}) begin tests_failed++; $display("FAIL full_commit got %b rd=%0d v=%h full=%b exp 1 rd=1 v=000000aa full=0", commit_valid, commit_rd, commit_value, rob_full); end
        disp(2'd0, 5'd7, 32'h400, 0, 0);
        step();
        tests_run++; if ({rob_full, rob_tail_id} !== {1'b1, 4'd1}) begin tests_failed++; $display("FAIL wrap_tail got %b/%0d exp 1/1", rob_full, rob_tail_id); end
        rs_has_output = 1; rs_rob_id = 0; rs_output = 32'h77;
        step();
        qry_i_id = 0;
        #1;
        tests_run++; if ({qry_i_ready, qry_i_value} !== {1'b1, 32'h77}) begin tests_failed++; $display("FAIL wrap_id0 got %b/%h exp 1/00000077", qry_i_ready, qry_i_value); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp(2'd0, 5'(10 + i), 32'(32'h500 + 4 * i), 0, 0);
            step();
        end
        is_lsb = 1; lsb_rob_id = 2; lsb_res = 32'h22;
        rs_has_output = 1; rs_rob_id = 0; rs_output = 32'h20;
        step();
        rs_has_output = 1; rs_rob_id = 1; rs_output = 32'h21;
        step();
        tests_run++; if ({commit_valid, commit_rob_id, commit_rd, commit_value} !== {1'b1, 4'd0, 5'd10, 32'h20}) begin tests_failed++; $display("FAIL ooo_c0 got %b id=%0d rd=%0d v=%h exp 1 id=0 rd=10 v=00000020", commit_valid, commit_rob_id, commit_rd, commit_value); end
        step();
        tests_run++; if ({commit_valid, commit_rob_id, commit_rd, commit_value} !== {1'b1, 4'd1, 5'd11, 32'h21}) begin tests_failed++; $display("FAIL ooo_c1 got %b id=%0d rd=%0d v=%h exp 1 id=1 rd=11 v=00000021", commit_valid, commit_rob_id, commit_rd, commit_value); end
        step();
        tests_run++; if ({commit_valid, commit_rob_id, commit_rd, commit_value} !== {1'b1, 4'd2, 5'd12, 32'h22}) begin tests_failed++; $display("FAIL ooo_c2 got %b id=%0d rd=%0d v=%h exp 1 id=2 rd=12 v=00000022", commit_valid, commit_rob_id, commit_rd, commit_value); end
        step();
        tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL ooo_end got %b exp 0", commit_valid); end
    endtask

    task automatic test_mispredict();
        do_reset();
        disp(2'd2, 5'd0, 32'h100, 1, 32'h104);
        step();
        for (int i = 0; i < 3; i++) begin
            disp(2'd0, 5'(i + 1), 32'(32'h108 + 4 * i), 0, 0);
            step();
        end
        rs_has_output = 1; rs_rob_id = 1; rs_output = 32'h11;
        is_lsb = 1; lsb_rob_id = 2; lsb_res = 32'h12;
        step();
        rs_has_output = 1; rs_rob_id = 0; rs_output = 32'h0;
        is_lsb = 1; lsb_rob_id = 3; lsb_res = 32'h13;
        step();
        disp(2'd0, 5'd9, 32'h900, 0, 0);
        step();
        qry_i_id = 1;
        #1;
        tests_run++; if ({bp_valid, bp_taken, bp_pc} !== {1'b1, 1'b0, 32'h100}) begin tests_failed++; $display("FAIL mp_bp got %b/%b/%h exp 1/0/00000100", bp_valid, bp_taken, bp_pc); end
        tests_run++; if ({rob_clear, clear_pc} !== {1'b1, 32'h104}) begin tests_failed++; $display("FAIL mp_clear got %b/%h exp 1/00000104", rob_clear, clear_pc); end
        tests_run++; if ({rob_tail_id, rob_full, commit_valid, qry_i_ready} !== {4'd0, 3'b000}) begin tests_failed++; $display("FAIL mp_flush got tail=%0d full=%b cv=%b rdy1=%b exp 0/0/0/0", rob_tail_id, rob_full, commit_valid, qry_i_ready); end
        disp(2'd0, 5'd8, 32'h800, 0, 0);
        rs_has_output = 1; rs_rob_id = 0; rs_output = 32'hFF;
        step();
        qry_i_id = 0;
        #1;
        tests_run++; if ({rob_clear, bp_valid, rob_tail_id, qry_i_ready} !== {2'b00, 4'd0, 1'b0}) begin tests_failed++; $display("FAIL mp_ignore got clr=%b bp=%b tail=%0d rdy0=%b exp 0/0/0/0", rob_clear, bp_valid, rob_tail_id, qry_i_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL mp_young_commit got %b exp 0 cycle %0d", commit_valid, i); end
        end
    endtask

    task automatic test_store_exit();
        do_reset();
        disp(2'd1, 5'd0, 32'h200, 0, 0);
        step();
        tests_run++; if ({rob_tail_id, store_commit} !== {4'd1, 1'b0}) begin tests_failed++; $display("FAIL st_disp got tail=%0d sc=%b exp 1/0", rob_tail_id, store_commit); end
        disp(2'd3, 5'd0, 32'h204, 0, 0);
        step();
        tests_run++; if ({store_commit, commit_rob_id, commit_valid, halt} !== {1'b1, 4'd0, 2'b00}) begin tests_failed++; $display("FAIL st_commit got sc=%b id=%0d cv=%b h=%b exp 1/0/0/0", store_commit, commit_rob_id, commit_valid, halt); end
        disp(2'd0, 5'd4, 32'h208, 0, 0);
        step();
        tests_run++; if ({halt, store_commit} !== 2'b10) begin tests_failed++; $display("FAIL exit_halt got h=%b sc=%b exp 1/0", halt, store_commit); end
        rs_has_output = 1; rs_rob_id = 2; rs_output = 32'h44;
        step();
        disp(2'd0, 5'd6, 32'h20c, 0, 0);
        step();
        tests_run++; if (rob_tail_id !== 4'd3) begin tests_failed++; $display("FAIL halt_no_disp got %0d exp 3", rob_tail_id); end
        step();
        step();
        qry_i_id = 2;
        #1;
        tests_run++; if ({halt, commit_valid, qry_i_ready, qry_i_value} !== {1'b1, 1'b0, 1'b1, 32'h44}) begin tests_failed++; $display("FAIL halt_sticky got h=%b cv=%b rdy=%b v=%h exp 1/0/1/00000044", halt, commit_valid, qry_i_ready, qry_i_value); end
    endtask

    task automatic test_reset_and_stall();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            disp(2'd0, 5'(i + 1), 32'(32'h600 + 4 * i), 0, 0);
            step();
        end
        rs_has_output = 1; rs_rob_id = 0; rs_output = 32'h55;
        step();
        step();
        tests_run++; if ({commit_valid, commit_value, rob_tail_id} !== {1'b1, 32'h55, 4'd8}) begin tests_failed++; $display("FAIL pre_rst got cv=%b v=%h tail=%0d exp 1/00000055/8", commit_valid, commit_value, rob_tail_id); end
        #2;
        rst_in = 0;
        #1;
        tests_run++; if ({commit_valid, rob_full, halt, rob_tail_id, commit_value, commit_rd} !== 44'd0) begin tests_failed++; $display("FAIL async_rst got cv=%b full=%b h=%b tail=%0d v=%h rd=%0d exp all 0", commit_valid, rob_full, halt, rob_tail_id, commit_value, commit_rd); end
        step();
        rst_in = 1;
        disp(2'd0, 5'd6, 32'h700, 0, 0);
        step();
        rs_has_output = 1; rs_rob_id = 0; rs_output = 32'h66;
        step();
        rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            disp(2'd0, 5'd9, 32'h704, 0, 0);
            step();
            tests_run++; if (commit_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_commit got %b exp 0 cycle %0d", commit_valid, i); end
        end
        tests_run++; if (rob_tail_id !== 4'd1) begin tests_failed++; $display("FAIL stall_tail got %0d exp 1", rob_tail_id); end
        rdy_in = 1;
        step();
        tests_run++; if ({commit_valid, commit_rd, commit_value} !== {1'b1, 5'd6, 32'h66}) begin tests_failed++; $display("FAIL resume_commit got %b rd=%0d v=%h exp 1 rd=6 v=00000066", commit_valid, commit_rd, commit_value); end
        rdy_in = 0;
        step();
        tests_run++; if ({commit_valid, commit_rd, commit_value} !== {1'b0, 5'd6, 32'h66}) begin tests_failed++; $display("FAIL stall_hold got %b rd=%0d v=%h exp 0 rd=6 v=00000066", commit_valid, commit_rd, commit_value); end
        rdy_in = 1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_full_wrap();
        test_out_of_order();
        test_mispredict();
        test_store_exit();
        test_reset_and_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
